// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register pending bits and a post-reset zero sweep.
// Latency: reads and rd_pend are combinational with same-cycle write bypass; writes/reservations commit at the rising edge.
// Backpressure: none; for DEPTH cycles after reset writes/reservations are dropped and reads return zero.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     init_done
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]    pending;
    logic                ready;

    // Unpacked views of the packed port buses, indexed by port number
    logic [ADDR_W-1:0]   wa  [NUM_WR];
    logic [DATA_W-1:0]   wd  [NUM_WR];
    logic [ADDR_W-1:0]   ra  [NUM_RD];
    logic [NUM_RD-1:0]   hit;
    logic [DATA_W-1:0]   fwd [NUM_RD];

    assign ready = (state == READY);

    // Slice the flat port buses little-endian by port index
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            wa[k] = waddr[k*ADDR_W +: ADDR_W];
            wd[k] = wdata[k*DATA_W +: DATA_W];
        end
        for (int j = 0; j < NUM_RD; j++) begin
            ra[j] = raddr[j*ADDR_W +: ADDR_W];
        end
    end

    // Clear-sweep FSM: walk ptr over every entry once, then sit in READY until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLEAR;
            ptr       <= '0;
            init_done <= 1'b0;
        end else if (state == CLEAR) begin
            ptr <= ptr + ADDR_W'(1);
            if (ptr == ADDR_W'(DEPTH - 1)) begin
                state     <= READY;
                init_done <= 1'b1;
            end
        end
    end

    // Storage: sweep zeroes one entry per cycle, afterwards ports write in ascending order so the highest index wins
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[ptr] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && wa[k] != '0) begin
                    regs[wa[k]] <= wd[k];
                end
            end
        end
    end

    // Pending bits: writes clear, a reservation applied last so it beats a same-cycle write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else if (ready) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && wa[k] != '0) begin
                    pending[wa[k]] <= 1'b0;
                end
            end
            if (rsv_en && rsv_addr != '0) begin
                pending[rsv_addr] <= 1'b1;
            end
        end
    end

    // Read ports: bypass from the highest-index matching write, gate to zero when idle, r0 or not ready
    always_comb begin
        rdata   = '0;
        rd_pend = '0;
        hit     = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            fwd[j] = regs[ra[j]];
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && wa[k] == ra[j]) begin
                    hit[j] = 1'b1;
                    fwd[j] = wd[k];
                end
            end
            if (ready && re[j] && ra[j] != '0) begin
                rdata[j*DATA_W +: DATA_W] = fwd[j];
                rd_pend[j]                = pending[ra[j]] & ~hit[j];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with default parameters.
// Inputs change on the falling edge; expectations are queued then compared 2ns later.
// Cycle-count waits are bounded and an expired bound shows up as a miscompare.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rd_pend;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        init_done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        int          port;
        bit          is_pend;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    // Reference state for the random phase
    logic [31:0] mdl  [32];
    bit          mpnd [32];

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rd_pend(rd_pend),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input int j, input logic [31:0] d, input bit p);
        exp_t e;
        e.tag = {tag, "_dat"}; e.port = j; e.is_pend = 1'b0; e.exp = d;
        sb.push_back(e);
        e.tag = {tag, "_pnd"}; e.is_pend = 1'b1; e.exp = {31'd0, p};
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_pend) got = {31'd0, rd_pend[e.port]};
            else           got = rdata[e.port*32 +: 32];
            chk(e.tag, got, e.exp);
        end
    endtask

    task automatic set_wr(input int k, input bit en, input logic [4:0] a, input logic [31:0] d);
        we[k]            = en;
        waddr[k*5 +: 5]  = a;
        wdata[k*32 +: 32] = d;
    endtask

    task automatic set_rd(input int j, input bit en, input logic [4:0] a);
        re[j]           = en;
        raddr[j*5 +: 5] = a;
    endtask

    task automatic idle();
        we = '0; re = '0; rsv_en = 1'b0;
    endtask

    // Count rising edges until init_done, checking after each edge; starts just after a falling edge
    task automatic wait_init(input string tag);
        int n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            @(posedge clk); n++; #1;
        end
        chk(tag, 32'(n), 32'd32);
    endtask

    task automatic rand_cycle(input int i);
        logic [4:0]  a;
        logic [31:0] d;
        bit          h;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            set_wr(k, 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
        for (int j = 0; j < 2; j++)
            set_rd(j, ($urandom_range(3) != 0), 5'($urandom_range(7)));
        rsv_en   = ($urandom_range(3) == 0);
        rsv_addr = 5'($urandom_range(7));
        for (int j = 0; j < 2; j++) begin
            a = raddr[j*5 +: 5];
            d = mdl[a];
            h = 1'b0;
            for (int k = 0; k < 2; k++)
                if (we[k] && waddr[k*5 +: 5] == a) begin h = 1'b1; d = wdata[k*32 +: 32]; end
            if (!re[j] || a == 5'd0) expect_rd($sformatf("rnd%0d_p%0d", i, j), j, 32'd0, 1'b0);
            else expect_rd($sformatf("rnd%0d_p%0d", i, j), j, d, mpnd[a] & ~h);
        end
        drain();
        for (int k = 0; k < 2; k++)
            if (we[k] && waddr[k*5 +: 5] != 5'd0) begin
                mdl[waddr[k*5 +: 5]]  = wdata[k*32 +: 32];
                mpnd[waddr[k*5 +: 5]] = 1'b0;
            end
        if (rsv_en && rsv_addr != 5'd0) mpnd[rsv_addr] = 1'b1;
    endtask

    initial begin
        rst = 1'b0; waddr = '0; wdata = '0; raddr = '0; rsv_addr = '0;
        idle();

        // Held in reset: outputs quiet even with reads enabled
        repeat (2) @(negedge clk);
        set_rd(0, 1'b1, 5'd3);
        set_rd(1, 1'b1, 5'd9);
        expect_rd("rst_hold_p0", 0, 32'd0, 1'b0);
        expect_rd("rst_hold_p1", 1, 32'd0, 1'b0);
        drain();
        chk("rst_init_done", {31'd0, init_done}, 32'd0);

        // Release with writes and a reservation to r4 held through the whole sweep
        @(negedge clk);
        rst = 1'b1;
        set_wr(0, 1'b1, 5'd4, 32'hFFFF_FFFF);
        set_wr(1, 1'b1, 5'd4, 32'hEEEE_EEEE);
        rsv_en = 1'b1; rsv_addr = 5'd4;
        set_rd(0, 1'b1, 5'd4);
        expect_rd("sweep_rd4", 0, 32'd0, 1'b0);
        drain();
        wait_init("init_cycles");
        idle();

        // Every register reads zero after the sweep; r4 carries no stale write or reservation
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            set_rd(0, 1'b1, 5'(a));
            set_rd(1, 1'b1, 5'(31 - a));
            expect_rd($sformatf("clr_r%0d", a), 0, 32'd0, 1'b0);
            expect_rd($sformatf("clr_r%0d", 31 - a), 1, 32'd0, 1'b0);
            drain();
        end

        // Dual write same address: higher port wins, bypassed now and stored next cycle; disabled port reads zero
        @(negedge clk); idle();
        set_wr(0, 1'b1, 5'd5, 32'hAAAA_0000);
        set_wr(1, 1'b1, 5'd5, 32'hBBBB_0000);
        set_rd(0, 1'b1, 5'd5);
        set_rd(1, 1'b0, 5'd5);
        expect_rd("byp_r5", 0, 32'hBBBB_0000, 1'b0);
        expect_rd("byp_re0", 1, 32'd0, 1'b0);
        drain();
        @(negedge clk); idle();
        set_rd(1, 1'b1, 5'd5);
        expect_rd("stored_r5", 1, 32'hBBBB_0000, 1'b0);
        drain();

        // Writes to r0 are discarded
        @(negedge clk); idle();
        set_wr(0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        set_rd(0, 1'b1, 5'd0);
        expect_rd("r0_same", 0, 32'd0, 1'b0);
        drain();
        @(negedge clk); idle();
        set_rd(0, 1'b1, 5'd0);
        expect_rd("r0_after", 0, 32'd0, 1'b0);
        drain();

        // Reserve r7, then write it: flag drops with the write and stays clear
        @(negedge clk); idle();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        set_rd(0, 1'b1, 5'd7);
        expect_rd("rsv7_same", 0, 32'd0, 1'b0);
        drain();
        @(negedge clk); idle();
        set_rd(0, 1'b1, 5'd7);
        expect_rd("rsv7_set", 0, 32'd0, 1'b1);
        drain();
        @(negedge clk); idle();
        set_wr(1, 1'b1, 5'd7, 32'h0000_0012);
        set_rd(0, 1'b1, 5'd7);
        expect_rd("rsv7_wr", 0, 32'h0000_0012, 1'b0);
        drain();
        @(negedge clk); idle();
        set_rd(0, 1'b1, 5'd7);
        expect_rd("rsv7_clr", 0, 32'h0000_0012, 1'b0);
        drain();

        // Reserve and write r9 together: reservation survives; reserve of r0 never flags
        @(negedge clk); idle();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        set_wr(0, 1'b1, 5'd9, 32'h0000_0099);
        drain();
        @(negedge clk); idle();
        rsv_en = 1'b1; rsv_addr = 5'd0;
        set_rd(0, 1'b1, 5'd9);
        expect_rd("rsv9_win", 0, 32'h0000_0099, 1'b1);
        drain();
        @(negedge clk); idle();
        set_rd(1, 1'b1, 5'd0);
        expect_rd("rsv_r0", 1, 32'd0, 1'b0);
        drain();

        // Reset from READY, then again ten cycles into the sweep
        @(negedge clk); idle();
        set_rd(0, 1'b1, 5'd9);
        rst = 1'b0;
        expect_rd("rst_ready_r9", 0, 32'd0, 1'b0);
        drain();
        chk("rst_ready_done", {31'd0, init_done}, 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_mid_done", {31'd0, init_done}, 32'd0);
        @(negedge clk); rst = 1'b1;
        #1 wait_init("reinit_cycles");
        @(negedge clk); idle();
        set_rd(0, 1'b1, 5'd9);
        set_rd(1, 1'b1, 5'd5);
        expect_rd("post_rst_r9", 0, 32'd0, 1'b0);
        expect_rd("post_rst_r5", 1, 32'd0, 1'b0);
        drain();

        // Random traffic on a small address window against the reference model
        for (int a = 0; a < 32; a++) begin mdl[a] = '0; mpnd[a] = 1'b0; end
        for (int i = 0; i < 300; i++) rand_cycle(i);

        @(negedge clk); idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NUM_WR, default 2, number of write ports (1..2).
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port we, input, NUM_WR, per-port write enable.
REQ-008 SHALL have port waddr, input, NUM_WR*ADDR_W, write addresses; port k uses slice k.
REQ-009 SHALL have port wdata, input, NUM_WR*DATA_W, write data; port k uses slice k.
REQ-010 SHALL have port re, input, NUM_RD, per-port read enable.
REQ-011 SHALL have port raddr, input, NUM_RD*ADDR_W, read addresses.
REQ-012 SHALL have port rdata, output, NUM_RD*DATA_W, read data (combinational).
REQ-013 SHALL have port rd_pend, output, NUM_RD, per-read-port "register reserved" flag.
REQ-014 SHALL have port rsv_en, input, 1, reserve request (marks a destination as pending).
REQ-015 SHALL have port rsv_addr, input, ADDR_W, register to reserve.
REQ-016 SHALL have port init_done, output, 1, high once the clear sweep has completed.

Function
REQ-017 SHALL implement FSM states CLEAR and READY; rst low forces CLEAR with sweep pointer 0.
REQ-018 In CLEAR, SHALL write zero to register[ptr] every cycle, ptr+1; after writing DEPTH-1 go to READY next edge (DEPTH cycles total).
REQ-019 In CLEAR, SHALL ignore we and rsv_en, drive rdata all zero and rd_pend all zero, init_done=0.
REQ-020 In READY, SHALL hold init_done=1 until next reset; READY is terminal.
REQ-021 Register 0 SHALL read as zero always; writes and reservations to address 0 SHALL be discarded.
REQ-022 In READY, write port k with we[k]=1 SHALL update register waddr[k] at the clock edge.
REQ-023 Two write ports on the same nonzero address in one cycle: higher port index SHALL win.
REQ-024 Read port j with re[j]=0 SHALL output zero; with raddr[j]=0 SHALL output zero.
REQ-025 Read port j SHALL bypass: if any enabled write port hits raddr[j] this cycle, output that wdata (highest index wins); otherwise stored value; zero-latency.
REQ-026 SHALL keep one pending bit per register; rsv_en=1 sets pending[rsv_addr] at the edge.
REQ-027 Any committed write to address a SHALL clear pending[a] at the edge.
REQ-028 Reserve and write to same address in same cycle: set SHALL win (pending stays 1).
REQ-029 rd_pend[j] SHALL equal re[j] & pending[raddr[j]] & ~(write hit on raddr[j] this cycle); zero for address 0.
REQ-030 Width rules: slices are little-endian by port index; no truncation or extension inside the block.

Reset
REQ-031 Asynchronous rst low SHALL immediately force: state CLEAR, ptr 0, init_done 0, all pending bits 0.
REQ-032 Register array contents SHALL NOT be reset directly; they become zero only via the sweep.
REQ-033 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.
REQ-034 Outputs during reset: rdata zero, rd_pend zero, init_done 0.

Verification
REQ-035 Release rst, count edges -> init_done rises after exactly 32 cycles (defaults); all 32 regs read 0.
REQ-036 READY: we=2'b11, waddr={5,5}, wdata={0xBBBB0000,0xAAAA0000} -> same-cycle read of r5 returns 0xBBBB0000 (bypass), next cycle stored 0xBBBB0000.
REQ-037 Write 0xDEADBEEF to r0, read raddr=0 with re=1 -> rdata 0, before and after edge.
REQ-038 rsv_en addr 7 -> rd_pend=1 reading r7; write r7 with 0x12 -> same cycle rd_pend=0, rdata 0x12; next cycle pending cleared.
REQ-039 rsv_en addr 9 and write r9 same cycle -> next cycle rd_pend for r9 =1.
REQ-040 Pulse rst low at sweep cycle 10 -> init_done 0, pending cleared, init_done rises 32 cycles after release.
